lfsr_stream_cipher: RTL and testbench

Parametrised LFSR substitution stream cipher and successor to cipher_core.
- Adds the following over cipher_core:
  - configurable LFSR width and taps, and a configurable symbol table range;
  - a run-time encrypt/decrypt mode;
  - a loadable seed;
  - valid/ready handshakes on input and output, with backpressure.
- Placement: sits between the character source (UART RX / message ROM) and the character sink.
- Characters inside the table are rotated by a keystream value. All other characters pass through unchanged.

---
 rtl/cipher_pkg.sv | 17 +
 rtl/galois_lfsr.sv | 28 ++
 rtl/lfsr_stream_cipher.sv | 110 +++++++++++
 tb/tb_lfsr_stream_cipher.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared constants for the LFSR substitution stream cipher: FSM state
// encoding, mode encoding and the default parameter values.
package cipher_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [7:0]  DEF_SYM_BASE     = 8'h20;
  localparam int          DEF_SYM_N        = 95;
  localparam int          DEF_K_BITS       = 7;
  localparam logic [15:0] DEF_TAPS         = 16'hB400;
  localparam logic [15:0] DEF_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/galois_lfsr.sv
// Galois LFSR with loadable seed. A zero seed would lock the register at
// zero forever, so it is replaced by SEED_DEFAULT on load.
module galois_lfsr #(
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(16'hB400),
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  // Reset and load take priority over stepping; a step shifts right and
  // folds the feedback mask in when the bit shifted out was one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED_DEFAULT;
    end else if (load) begin
      state <= (load_val == '0) ? SEED_DEFAULT : load_val;
    end else if (step) begin
      state <= (state >> 1) ^ (state[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/lfsr_stream_cipher.sv
// LFSR substitution stream cipher. Characters inside the symbol table are
// rotated by a keystream value taken from the LFSR; everything else passes
// through untouched. Single output register with valid/ready handshakes.
module lfsr_stream_cipher
  import cipher_pkg::*;
#(
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(DEF_SEED_DEFAULT),
  parameter logic [7:0]        SYM_BASE     = DEF_SYM_BASE,
  parameter int                SYM_N        = DEF_SYM_N,
  parameter int                K_BITS       = DEF_K_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_in_table,
  output logic [15:0]       char_count,
  output logic              running
);

  localparam logic [8:0] N9 = 9'(SYM_N);

  logic [0:0]        state;
  logic [LFSR_W-1:0] lfsr;
  logic              in_fire;
  logic              in_table;
  logic              lfsr_step;
  logic [7:0]        idx;
  logic [8:0]        kr9;
  logic [8:0]        k9;
  logic [8:0]        enc_sum;
  logic signed [8:0] dec_diff;
  logic [8:0]        o9;
  logic [7:0]        sub_char;

  galois_lfsr #(
    .LFSR_W      (LFSR_W),
    .TAPS        (TAPS),
    .SEED_DEFAULT(SEED_DEFAULT)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (seed_load),
    .load_val(seed),
    .step    (lfsr_step),
    .state   (lfsr)
  );

  // Accept input only in RUN, never during a reseed, and only when the
  // output register is empty or being drained this cycle.
  always_comb begin
    running   = (state == ST_RUN);
    in_ready  = running && !seed_load && (!out_valid || out_ready);
    in_fire   = in_valid && in_ready;
    lfsr_step = in_fire && in_table;
  end

  // Table lookup and modular rotation; the keystream uses the LFSR value
  // before it steps, so the first character after a load uses the seed.
  always_comb begin
    idx      = in_data - SYM_BASE;
    in_table = (in_data >= SYM_BASE) && ({1'b0, idx} < N9);
    kr9      = 9'(lfsr[K_BITS-1:0]);
    k9       = (kr9 >= N9) ? (kr9 - N9) : kr9;
    enc_sum  = {1'b0, idx} + k9;
    dec_diff = $signed({1'b0, idx}) - $signed(k9);
    if (mode == MODE_DEC) begin
      o9 = dec_diff[8] ? ($unsigned(dec_diff) + N9) : $unsigned(dec_diff);
    end else begin
      o9 = (enc_sum >= N9) ? (enc_sum - N9) : enc_sum;
    end
    sub_char = SYM_BASE + o9[7:0];
  end

  // FSM, output register and in-table counter. A reseed flushes any
  // pending output; a new input overwrites the register even while the
  // previous character is being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      out_valid    <= 1'b0;
      out_data     <= 8'h00;
      out_in_table <= 1'b0;
      char_count   <= 16'h0000;
    end else if (seed_load) begin
      state      <= ST_RUN;
      out_valid  <= 1'b0;
      char_count <= 16'h0000;
    end else if (in_fire) begin
      out_valid    <= 1'b1;
      out_data     <= in_table ? sub_char : in_data;
      out_in_table <= in_table;
      if (in_table) begin
        char_count <= char_count + 16'd1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Testbench for lfsr_stream_cipher: directed vector table, hand-written
// backpressure/reseed/reset sequences and a randomized phase checked
// against a modular-arithmetic reference model.
module tb_lfsr_stream_cipher;

  localparam int          SYM_N    = 95;
  localparam int          SYM_BASE = 32;
  localparam int          KMASK    = 127;
  localparam int          TAPS_I   = 'hB400;
  localparam int          SEED_DEF = 'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_in_table;
  logic [15:0] char_count;
  logic        running;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic        do_load;
    logic [15:0] seed;
    logic        mode;
    logic [7:0]  in_data;
    logic [7:0]  exp_data;
    logic        exp_table;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[11];

  // reference model state
  int m_lfsr;
  int m_valid;
  int m_data;
  int m_table;
  int m_count;

  lfsr_stream_cipher dut (
    .clk         (clk),
    .rst         (rst),
    .seed_load   (seed_load),
    .seed        (seed),
    .mode        (mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_in_table(out_in_table),
    .char_count  (char_count),
    .running     (running)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic m,
                               input logic ordy, input logic sl, input logic [15:0] s);
    in_valid  = v;
    in_data   = d;
    mode      = m;
    out_ready = ordy;
    seed_load = sl;
    seed      = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_data", 32'(out_data), 0);
    checkOutput("rst_out_in_table", 32'(out_in_table), 0);
    checkOutput("rst_char_count", 32'(char_count), 0);
    checkOutput("rst_running", 32'(running), 0);
  endtask

  // Keystream and rotation computed with plain modular arithmetic.
  function automatic int model_cipher(input int ch, input int lfsr_val, input int md);
    int idx;
    int k;
    idx = ch - SYM_BASE;
    k   = (lfsr_val & KMASK) % SYM_N;
    if (md == 0) return SYM_BASE + ((idx + k) % SYM_N);
    return SYM_BASE + ((idx - k + SYM_N) % SYM_N);
  endfunction

  function automatic int model_step(input int s);
    if (s % 2 == 1) return (s / 2) ^ TAPS_I;
    return s / 2;
  endfunction

  function automatic bit model_in_table(input int ch);
    return (ch >= SYM_BASE) && (ch < SYM_BASE + SYM_N);
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 16'h0001, 1'b0, 8'h41, 8'h42, 1'b1, 16'd1};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 8'h41, 8'h41, 1'b1, 16'd2};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 8'h41, 8'h41, 1'b1, 16'd3};
    vecs[3]  = '{1'b1, 16'h005E, 1'b0, 8'h7E, 8'h7D, 1'b1, 16'd1};
    vecs[4]  = '{1'b1, 16'h0001, 1'b1, 8'h42, 8'h41, 1'b1, 16'd1};
    vecs[5]  = '{1'b1, 16'h0002, 1'b1, 8'h20, 8'h7D, 1'b1, 16'd1};
    vecs[6]  = '{1'b1, 16'h0001, 1'b0, 8'h0A, 8'h0A, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 8'h41, 8'h42, 1'b1, 16'd1};
    vecs[8]  = '{1'b1, 16'h0000, 1'b0, 8'h20, 8'h22, 1'b1, 16'd1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 8'h7F, 8'h7F, 1'b0, 16'd1};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 8'h1F, 8'h1F, 1'b0, 16'd1};

    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000);
    tick();
    tick();
    checkReset();
    checkOutput("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;

    // IDLE: input offered but never accepted
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 16'h0000);
    #1;
    checkOutput("idle_in_ready", 32'(in_ready), 0);
    tick();
    tick();
    checkOutput("idle_out_valid", 32'(out_valid), 0);
    checkOutput("idle_running", 32'(running), 0);

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_load) begin
        applyStimulus(1'b0, 8'h00, vecs[i].mode, 1'b1, 1'b1, vecs[i].seed);
        tick();
        checkOutput($sformatf("vec%0d_load_valid", i), 32'(out_valid), 0);
      end
      applyStimulus(1'b1, vecs[i].in_data, vecs[i].mode, 1'b1, 1'b0, 16'h0000);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
      checkOutput($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d_in_table", i), 32'(out_in_table), 32'(vecs[i].exp_table));
      checkOutput($sformatf("vec%0d_count", i), 32'(char_count), 32'(vecs[i].exp_count));
      applyStimulus(1'b0, 8'h00, vecs[i].mode, 1'b1, 1'b0, 16'h0000);
    end
    tick();
    checkOutput("drain_valid", 32'(out_valid), 0);

    // backpressure: first output held for 5 cycles, stream then resumes
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0001);
    tick();
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkOutput("bp_first", 32'(out_data), 32'h42);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput($sformatf("bp_ready_%0d", c), 32'(in_ready), 0);
      tick();
      checkOutput($sformatf("bp_hold_data_%0d", c), 32'(out_data), 32'h42);
      checkOutput($sformatf("bp_hold_valid_%0d", c), 32'(out_valid), 1);
    end
    checkOutput("bp_count_held", 32'(char_count), 1);
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 16'h0000);
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 1);
    tick();
    checkOutput("bp_second", 32'(out_data), 32'h41);
    tick();
    checkOutput("bp_third", 32'(out_data), 32'h41);
    checkOutput("bp_count", 32'(char_count), 3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000);
    tick();
    checkOutput("bp_drained", 32'(out_valid), 0);

    // reseed while an output is pending flushes it and blocks input
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkOutput("reseed_pending", 32'(out_valid), 1);
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 16'h0001);
    #1;
    checkOutput("reseed_in_ready", 32'(in_ready), 0);
    tick();
    checkOutput("reseed_flush", 32'(out_valid), 0);
    checkOutput("reseed_count", 32'(char_count), 0);
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 16'h0000);
    tick();
    checkOutput("reseed_restart", 32'(out_data), 32'h42);

    // reset mid-stream, together with a seed load, wins
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 16'h0005);
    rst = 1'b1;
    tick();
    checkReset();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000);

    // randomized phase against the reference model
    m_lfsr = 0; m_valid = 0; m_data = 0; m_table = 0; m_count = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        r_v, r_m, r_or, r_sl;
      logic [7:0]  r_d;
      logic [15:0] r_s;
      int          exp_ready;
      r_sl = (cyc == 0) || ($urandom_range(0, 39) == 0);
      r_v  = ($urandom_range(0, 3) != 0);
      r_m  = 1'($urandom_range(0, 1));
      r_or = ($urandom_range(0, 3) != 0);
      r_d  = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(32, 126)) : 8'($urandom_range(0, 255));
      r_s  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      applyStimulus(r_v, r_d, r_m, r_or, r_sl, r_s);
      #1;
      exp_ready = (cyc > 0) && !r_sl && (!m_valid || r_or);
      checkOutput("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
      if (r_sl) begin
        m_lfsr  = (r_s == 0) ? SEED_DEF : int'(r_s);
        m_count = 0;
        m_valid = 0;
      end else if (r_v && exp_ready) begin
        m_valid = 1;
        if (model_in_table(int'(r_d))) begin
          m_data  = model_cipher(int'(r_d), m_lfsr, int'(r_m));
          m_table = 1;
          m_count = (m_count + 1) % 65536;
          m_lfsr  = model_step(m_lfsr);
        end else begin
          m_data  = int'(r_d);
          m_table = 0;
        end
      end else if (m_valid && r_or) begin
        m_valid = 0;
      end
      tick();
      checkOutput("rnd_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        checkOutput("rnd_out_data", 32'(out_data), 32'(m_data));
        checkOutput("rnd_out_in_table", 32'(out_in_table), 32'(m_table));
      end
      checkOutput("rnd_char_count", 32'(char_count), 32'(m_count));
      checkOutput("rnd_running", 32'(running), 1);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
